// File: rtl/instr_fetch.sv
// instr_fetch: PC holder and instruction-memory read initiator with valid/ready hand-off to decode
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          READ_WAIT  = 2,
  parameter int          PROG_BYTES = 20
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        done
);
  localparam int              CW       = READ_WAIT > 1 ? $clog2(READ_WAIT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(READ_WAIT - 1);
  localparam logic [31:0]     PROG_END = 32'(PROG_BYTES);
  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_DONE} state_t;
  state_t        r_state;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_instr;
  logic [31:0]   r_pc_out;
  logic          r_valid;
  logic          r_done;
  logic          w_accept;
  logic [31:0]   w_target;
  logic          w_unused_bits;
  assign w_accept      = r_valid && instr_ready;
  assign w_target      = {branch_target[31:2], 2'b00};
  assign w_unused_bits = &{1'b0, branch_target[1:0]};
  assign mem_addr      = r_pc;
  assign instr_out     = r_instr;
  assign pc_out        = r_pc_out;
  assign instr_valid   = r_valid;
  assign done          = r_done;
  // Fetch sequencer: redirect overrides everything, otherwise wait/capture/hold/stop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_WAIT;
      r_pc     <= RESET_PC;
      r_cnt    <= '0;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else if (branch_valid) begin
      r_state <= S_WAIT;
      r_pc    <= w_target;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == CNT_LAST) begin
            r_instr  <= mem_instr;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + 32'd4;
            r_cnt    <= '0;
            r_state  <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= (r_pc >= PROG_END) ? S_DONE : S_WAIT;
            r_done  <= (r_pc >= PROG_END);
          end
        end
        S_DONE: r_done <= 1'b1;
        default: r_state <= S_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch
module tb_instr_fetch;
  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        done;
  int errors = 0;
  int checks = 0;
  int hs8 = 0;
  int n;
  int base;

  instr_fetch #(.RESET_PC(32'd0), .READ_WAIT(2), .PROG_BYTES(20)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_instr(mem_instr),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_valid(branch_valid),
    .branch_target(branch_target), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h58000001;
      32'd4:   return 32'h08800002;
      32'd8:   return 32'h20800001;
      32'd12:  return 32'h10009000;
      32'd16:  return 32'h08000002;
      default: return 32'hDEAD0000 ^ a;
    endcase
  endfunction

  assign mem_instr = mem_f(mem_addr);

  always @(posedge clk) if (instr_valid && instr_ready && pc_out == 32'd8) hs8 <= hs8 + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!instr_valid && cyc < 20);
  endtask

  task automatic pulse_branch(input logic [31:0] t);
    branch_valid  = 1;
    branch_target = t;
    tick();
    branch_valid  = 0;
  endtask

  initial begin
    reset = 0; instr_ready = 0; branch_valid = 0; branch_target = 0;
    #2;
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    #1 reset = 1;
    // first fetch and back-pressure
    wait_valid(n);
    chk("first_latency", n, 32'd2);
    chk("first_instr", instr_out, 32'h58000001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", instr_out, 32'h58000001);
      chk("bp_pc_out", pc_out, 32'd0);
      chk("bp_mem_addr", mem_addr, 32'd4);
    end
    // straight line
    instr_ready = 1;
    for (int a = 4; a <= 16; a += 4) begin
      wait_valid(n);
      chk("line_spacing", n, 32'd3);
      chk("line_pc_out", pc_out, 32'(a));
      chk("line_instr", instr_out, mem_f(32'(a)));
    end
    tick();
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_valid", {31'd0, instr_valid}, 32'd0);
    chk("end_mem_addr", mem_addr, 32'd20);
    tick();
    chk("end_done_hold", {31'd0, done}, 32'd1);
    chk("end_pc_frozen", mem_addr, 32'd20);
    // branch out of DONE
    pulse_branch(32'd0);
    chk("done_br_done", {31'd0, done}, 32'd0);
    chk("done_br_addr", mem_addr, 32'd0);
    wait_valid(n);
    chk("done_br_lat", n, 32'd2);
    chk("done_br_pc", pc_out, 32'd0);
    chk("done_br_instr", instr_out, 32'h58000001);
    // branch in HOLD squashes unaccepted instruction
    wait_valid(n);
    wait_valid(n);
    chk("hold_pc8", pc_out, 32'd8);
    instr_ready = 0;
    pulse_branch(32'd16);
    instr_ready = 1;
    chk("sq_valid", {31'd0, instr_valid}, 32'd0);
    chk("sq_addr", mem_addr, 32'd16);
    wait_valid(n);
    chk("sq_lat", n, 32'd2);
    chk("sq_pc_out", pc_out, 32'd16);
    chk("sq_instr", instr_out, 32'h08000002);
    tick();
    chk("sq_done", {31'd0, done}, 32'd1);
    // branch coincident with handshake
    pulse_branch(32'd0);
    wait_valid(n);
    wait_valid(n);
    wait_valid(n);
    chk("co_pc8", pc_out, 32'd8);
    base = hs8;
    pulse_branch(32'd17);
    chk("co_hs_once", hs8 - base, 32'd1);
    chk("co_addr", mem_addr, 32'd16);
    wait_valid(n);
    chk("co_pc_out", pc_out, 32'd16);
    chk("co_hs_total", hs8 - base, 32'd1);
    // async reset mid-WAIT
    tick();
    pulse_branch(32'd12);
    tick();
    chk("ar_pre_addr", mem_addr, 32'd12);
    #2 reset = 0;
    #1;
    chk("ar_addr", mem_addr, 32'd0);
    chk("ar_pc_out", pc_out, 32'd0);
    chk("ar_instr", instr_out, 32'd0);
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    #1 reset = 1;
    wait_valid(n);
    chk("ar_lat", n, 32'd2);
    chk("ar_restart_pc", pc_out, 32'd0);
    chk("ar_restart_instr", instr_out, 32'h58000001);
    // wrap-around
    pulse_branch(32'hFFFFFFFF);
    chk("wr_addr", mem_addr, 32'hFFFFFFFC);
    wait_valid(n);
    chk("wr_pc_out", pc_out, 32'hFFFFFFFC);
    chk("wr_instr", instr_out, mem_f(32'hFFFFFFFC));
    chk("wr_next_addr", mem_addr, 32'd0);
    wait_valid(n);
    chk("wr_spacing", n, 32'd3);
    chk("wr_pc0", pc_out, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
